// File: rtl/fifo_pkg.sv
// Shared types, defaults and parameter-check helpers for the synchronous FIFO family.
package fifo_pkg;

    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultDepth = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read into a read-enable-gated register.
module fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky error flags.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DefaultDataW,
    parameter int unsigned DEPTH    = DefaultDepth,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic                   r_en,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CntW   = ADDR_W + 1;

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_chk
        $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
        $error("param_sync_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (AE_LEVEL > DEPTH - 1 || AE_LEVEL >= AF_LEVEL) begin : g_ae_chk
        $error("param_sync_fifo: AE_LEVEL out of range or not below AF_LEVEL");
    end

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_acc, wr_acc;
    fifo_status_t      status;

    assign status.full         = (count_q == CntW'(DEPTH));
    assign status.empty        = (count_q == '0);
    assign status.almost_full  = (count_q >= CntW'(AF_LEVEL));
    assign status.almost_empty = (count_q <= CntW'(AE_LEVEL));

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign rd_acc = r_en && !status.empty;
    assign wr_acc = wr_en && (!status.full || rd_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Clear first so a coincident new error wins.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (r_en && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .we_i     (wr_acc && reset_n),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (data_in),
        .re_i     (rd_acc && reset_n),
        .raddr_i  (rd_ptr_q),
        .rdata_o  (data_out)
    );

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_param_sync_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AF     = 12;
    localparam int unsigned AE     = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              r_en = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic              full, empty, almost_full, almost_empty;
    logic [4:0]        count;
    logic              overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: occupancy is simply the queue length.
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] dout_m = '0;
    bit                ovf_m = 1'b0;
    bit                udf_m = 1'b0;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .r_en         (r_en),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive request, advance the model, then compare every output.
    task automatic step(input bit w, input bit r, input bit e, input bit rst,
                        input logic [DATA_W-1:0] d);
        int  n;
        bit  racc, wacc;
        wr_en   = w;
        r_en    = r;
        err_clr = e;
        reset_n = !rst;
        data_in = d;
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            dout_m = '0;
            ovf_m  = 1'b0;
            udf_m  = 1'b0;
        end else begin
            n    = model_q.size();
            racc = r && (n > 0);
            wacc = w && ((n < DEPTH) || racc);
            if (racc) dout_m = model_q.pop_front();
            if (wacc) model_q.push_back(d);
            if (w && !wacc) ovf_m = 1'b1;
            else if (e)     ovf_m = 1'b0;
            if (r && !racc) udf_m = 1'b1;
            else if (e)     udf_m = 1'b0;
        end
        wr_en   = 1'b0;
        r_en    = 1'b0;
        err_clr = 1'b0;
        reset_n = 1'b1;
        n = model_q.size();
        chk("count", 32'(count), n);
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
        chk("data_out", 32'(data_out), 32'(dout_m));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        chk("underflow", 32'(underflow), 32'(udf_m));
    endtask

    task automatic wr(input logic [DATA_W-1:0] d);
        step(1'b1, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic rd();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        int                wp;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_data_out", 32'(data_out), 0);

        // Fill 0x01..0x10, watch threshold edges
        for (int i = 1; i <= 16; i++) begin
            wr(8'(i));
            if (i == 11) chk("af_below", 32'(almost_full), 0);
            if (i == 12) chk("af_rise", 32'(almost_full), 1);
            if (i == 2)  chk("ae_hold", 32'(almost_empty), 1);
            if (i == 3)  chk("ae_fall", 32'(almost_empty), 0);
        end
        chk("fill_full", 32'(full), 1);
        wr(8'hEE);
        chk("ovf_17th", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            rd();
            chk("drain_order", 32'(data_out), i);
        end
        chk("drain_empty", 32'(empty), 1);
        rd();
        chk("udf_set", 32'(underflow), 1);

        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_udf", 32'(underflow), 0);

        // Wrap-around
        for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            rd();
            chk("wrap_a", 32'(data_out), 32'h A0 + i);
        end
        for (int i = 0; i < 10; i++) wr(8'hB0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            rd();
            chk("wrap_b", 32'(data_out), 32'h B0 + i);
        end
        chk("wrap_count", 32'(count), 0);

        // Simultaneous access when full
        for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
        chk("full_rw_count", 32'(count), 16);
        chk("full_rw_ovf", 32'(overflow), 0);

        // Simultaneous access when empty
        for (int i = 0; i < 16; i++) rd();
        held = data_out;
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        chk("empty_rw_count", 32'(count), 1);
        chk("empty_rw_udf", 32'(underflow), 1);
        chk("empty_rw_dout", 32'(data_out), 32'(held));

        // err_clr racing a new rejected write
        for (int i = 0; i < 15; i++) wr(8'(i));
        wr(8'h99);
        chk("ovf_before_clr", 32'(overflow), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h98);
        chk("set_wins_ovf", 32'(overflow), 1);
        chk("set_wins_udf", 32'(underflow), 0);

        // Reset mid-operation with count 7
        for (int i = 0; i < 9; i++) rd();
        chk("pre_rst_count", 32'(count), 7);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h33);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_dout", 32'(data_out), 0);
        chk("mid_rst_udf", 32'(underflow), 0);
        wr(8'h5A);
        rd();
        chk("post_rst_data", 32'(data_out), 32'h5A);

        // Random traffic with varying write bias
        for (int ph = 0; ph < 4; ph++) begin
            wp = (ph == 0) ? 75 : (ph == 1) ? 25 : (ph == 2) ? 50 : 90;
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 99) < wp),
                     ($urandom_range(0, 99) < (100 - wp)),
                     ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 299) == 0),
                     8'($urandom_range(0, 255)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
